replicated_output_serializer: RTL and testbench

// - Downstream consumer of the replicated polynomial pipeline. It accepts one NUM_REPLICATIONS-wide result vector
//   per valid_in cycle and buffers it in a vector FIFO.
// - It emits the lanes one at a time on a valid/ready stream, lane 0 first.
// - The upstream pipeline has no backpressure, so this block absorbs bursts and flags any vector it has to drop.
//

---
 rtl/replicated_output_serializer_if.sv | 44 ++++
 rtl/replicated_output_serializer.sv | 119 +++++++++++
 tb/tb_replicated_output_serializer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/replicated_output_serializer_if.sv
// Stream bundle between the replicated pipeline, the vector serializer and its lane consumer.
// The lane_id field exists only when SERIALIZER_LANE_ID_EN is defined.
interface replicated_output_serializer_if #(
    parameter int WIDTH            = 32,
    parameter int NUM_REPLICATIONS = 8,
    parameter int FIFO_DEPTH       = 4
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic             valid_in;
    logic [WIDTH-1:0] in [NUM_REPLICATIONS];
    logic             ready;
    logic             valid_out;
    logic [WIDTH-1:0] out;
    logic             last;
    logic [CW-1:0]    count;
    logic             overflow;

`ifdef SERIALIZER_LANE_ID_EN
    localparam int LW = $clog2(NUM_REPLICATIONS);
    logic [LW-1:0]    lane_id;

    modport master (
        output valid_in, in, ready,
        input  valid_out, out, last, count, overflow, lane_id
    );

    modport slave (
        input  valid_in, in, ready,
        output valid_out, out, last, count, overflow, lane_id
    );
`else
    modport master (
        output valid_in, in, ready,
        input  valid_out, out, last, count, overflow
    );

    modport slave (
        input  valid_in, in, ready,
        output valid_out, out, last, count, overflow
    );
`endif

endinterface

// File: rtl/replicated_output_serializer.sv
// Buffers NUM_REPLICATIONS-wide result vectors in a vector FIFO and streams their lanes out, lane 0 first.
// Optional feature macro: SERIALIZER_LANE_ID_EN adds a lane_id output carrying the index of the lane on out.
module replicated_output_serializer #(
    parameter int WIDTH            = 32,
    parameter int NUM_REPLICATIONS = 8,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    replicated_output_serializer_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(NUM_REPLICATIONS);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] LP_PTR_MAX    = PW'(FIFO_DEPTH - 1);
    localparam logic [LW-1:0] LP_LANE_MAX   = LW'(NUM_REPLICATIONS - 1);
    localparam logic [CW-1:0] LP_COUNT_FULL = CW'(FIFO_DEPTH);

    logic [WIDTH-1:0] r_mem [FIFO_DEPTH][NUM_REPLICATIONS];

    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [LW-1:0] r_lane;
    logic          r_overflow;

    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_rd_ptr_nxt;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [LW-1:0] w_lane_nxt;
    logic          w_overflow_nxt;

    logic w_valid;
    logic w_last;
    logic w_xfer;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;

    // Depth need not be a power of two, so wrap by compare rather than by truncation.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LP_PTR_MAX) ? '0 : ptr + PW'(1);
    endfunction

    assign w_valid = (r_count != '0);
    assign w_last  = w_valid && (r_lane == LP_LANE_MAX);
    assign w_xfer  = w_valid && bus.ready;
    assign w_pop   = w_xfer && w_last;
    assign w_full  = (r_count == LP_COUNT_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO can still take the incoming vector.
    assign w_push  = bus.valid_in && (!w_full || w_pop);
    assign w_drop  = bus.valid_in && w_full && !w_pop;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_count_nxt    = r_count;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_lane_nxt     = r_lane;
        w_overflow_nxt = r_overflow;

        if (w_xfer) begin
            w_lane_nxt = w_last ? '0 : r_lane + LW'(1);
        end
        if (w_pop) begin
            w_rd_ptr_nxt = f_ptr_inc(r_rd_ptr);
        end
        if (w_push) begin
            w_wr_ptr_nxt = f_ptr_inc(r_wr_ptr);
        end

        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase

        if (w_drop) begin
            w_overflow_nxt = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_lane     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_lane     <= w_lane_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.in;
        end
    end

    assign bus.valid_out = w_valid;
    assign bus.out       = w_valid ? r_mem[r_rd_ptr][r_lane] : '0;
    assign bus.last      = w_last;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;

`ifdef SERIALIZER_LANE_ID_EN
    assign bus.lane_id   = r_lane;
`endif

endmodule

// File: tb/tb_replicated_output_serializer.sv
// Randomized and directed bench for replicated_output_serializer, checked every cycle against a queue model.
// Exercises SERIALIZER_LANE_ID_EN when that macro is defined.
module tb_replicated_output_serializer;
    localparam int WIDTH = 32;
    localparam int NR    = 8;
    localparam int DEPTH = 4;

    typedef logic [NR-1:0][WIDTH-1:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    replicated_output_serializer_if #(
        .WIDTH(WIDTH), .NUM_REPLICATIONS(NR), .FIFO_DEPTH(DEPTH)
    ) bus ();

    replicated_output_serializer #(
        .WIDTH(WIDTH), .NUM_REPLICATIONS(NR), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of whole vectors plus the index of the lane being offered.
    vec_t             m_q[$];
    int               m_lane = 0;
    logic             m_ovf  = 1'b0;
    bit               chk_en = 1'b0;
    logic [WIDTH-1:0] got[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        vec_t v;
        bit   accept;
        if (!rst) begin
            m_q.delete();
            m_lane = 0;
            m_ovf  = 1'b0;
            chk_en = 1'b1;
            return;
        end
        for (int i = 0; i < NR; i++) v[i] = bus.in[i];
        accept = bus.valid_in &&
                 (m_q.size() < DEPTH || (m_q.size() != 0 && bus.ready && m_lane == NR - 1));
        if (bus.valid_in && !accept) m_ovf = 1'b1;
        if (m_q.size() != 0 && bus.ready) begin
            if (m_lane == NR - 1) begin
                void'(m_q.pop_front());
                m_lane = 0;
            end else begin
                m_lane++;
            end
        end
        if (accept) m_q.push_back(v);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Compare and transfer monitor, sampled mid-cycle on the falling edge.
    initial forever begin
        logic             exp_valid;
        logic [WIDTH-1:0] exp_out;
        @(negedge clk);
        if (chk_en) begin
            exp_valid = (m_q.size() != 0);
            if (exp_valid) exp_out = m_q[0][m_lane];
            else           exp_out = '0;
            check("valid_out", bus.valid_out, exp_valid);
            check("out",       bus.out,       exp_out);
            check("last",      bus.last,      exp_valid && m_lane == NR - 1);
            check("count",     bus.count,     m_q.size());
            check("overflow",  bus.overflow,  m_ovf);
`ifdef SERIALIZER_LANE_ID_EN
            check("lane_id",   bus.lane_id,   m_lane);
`endif
            if (rst && bus.valid_out && bus.ready) got.push_back(bus.out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input int base);
        for (int i = 0; i < NR; i++) bus.in[i] = WIDTH'(base + i);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (bus.valid_out && n < limit) begin
            tick();
            n++;
        end
        check("drain_done", bus.valid_out, 1'b0);
    endtask

    initial begin
        int cycles;
        bus.valid_in = 1'b1;
        bus.ready    = 1'b1;
        set_vec(32'h55);

        // Reset held with traffic present
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_valid", bus.valid_out, 1'b0);
            check("rst_count", bus.count, 0);
            check("rst_ovf",   bus.overflow, 1'b0);
            check("rst_out",   bus.out, 0);
        end
        rst = 1'b1;
        bus.valid_in = 1'b0;
        repeat (3) tick();
        check("post_rst_valid", bus.valid_out, 1'b0);

        // Single vector, ready high
        set_vec(100);
        bus.valid_in = 1'b1;
        got.delete();
        tick();
        bus.valid_in = 1'b0;
        for (int k = 0; k < NR; k++) begin
            check("single_out",  bus.out, 100 + k);
            check("single_last", bus.last, k == NR - 1);
            tick();
        end
        check("single_empty", bus.valid_out, 1'b0);
        check("single_count", bus.count, 0);
        check("single_n", got.size(), NR);

        // Backpressure: ready alternates starting with 0 on the first lane cycle
        set_vec(100);
        bus.valid_in = 1'b1;
        bus.ready    = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        got.delete();
        cycles = 0;
        while (bus.valid_out && cycles < 40) begin
            bus.ready = (cycles % 2 == 1);
            tick();
            cycles++;
        end
        check("bp_cycles", cycles, 16);
        check("bp_n", got.size(), NR);
        for (int i = 0; i < got.size(); i++) check("bp_order", got[i], 100 + i);

        // Overflow: four vectors stored, fifth dropped
        bus.ready = 1'b0;
        for (int v = 0; v < DEPTH; v++) begin
            set_vec(200 + v * 10);
            bus.valid_in = 1'b1;
            tick();
        end
        check("ovf_count4", bus.count, DEPTH);
        check("ovf_clear", bus.overflow, 1'b0);
        set_vec(900);
        tick();
        bus.valid_in = 1'b0;
        check("ovf_set",   bus.overflow, 1'b1);
        check("ovf_count", bus.count, DEPTH);
        got.delete();
        bus.ready = 1'b1;
        drain(100);
        check("ovf_n", got.size(), DEPTH * NR);
        for (int k = 0; k < got.size(); k++) check("ovf_order", got[k], 200 + (k / NR) * 10 + k % NR);
        check("ovf_sticky", bus.overflow, 1'b1);

        // Full FIFO with write in the cycle the last lane transfers
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        check("fp_ovf0", bus.overflow, 1'b0);
        bus.ready = 1'b0;
        for (int v = 0; v < DEPTH; v++) begin
            set_vec(400 + v * 10);
            bus.valid_in = 1'b1;
            tick();
        end
        bus.valid_in = 1'b0;
        got.delete();
        bus.ready = 1'b1;
        cycles = 0;
        while (!bus.last && cycles < 20) begin
            tick();
            cycles++;
        end
        check("fp_last",  bus.last, 1'b1);
        check("fp_full",  bus.count, DEPTH);
        set_vec(300);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        check("fp_ovf",   bus.overflow, 1'b0);
        check("fp_count", bus.count, DEPTH);
        drain(100);
        check("fp_n", got.size(), (DEPTH + 1) * NR);
        if (got.size() == (DEPTH + 1) * NR)
            for (int i = 0; i < NR; i++) check("fp_new", got[DEPTH * NR + i], 300 + i);

        // Reset while lane 3 is on out, with overflow already set
        bus.ready = 1'b0;
        set_vec(100);
        bus.valid_in = 1'b1;
        repeat (DEPTH + 1) tick();
        bus.valid_in = 1'b0;
        check("mr_ovf1", bus.overflow, 1'b1);
        bus.ready = 1'b1;
        repeat (3) tick();
        check("mr_lane3", bus.out, 103);
        rst = 1'b0;
        tick();
        check("mr_valid", bus.valid_out, 1'b0);
        check("mr_count", bus.count, 0);
        check("mr_ovf",   bus.overflow, 1'b0);
        check("mr_out",   bus.out, 0);
        rst = 1'b1;
        set_vec(500);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
        check("mr_restart", bus.out, 500);
        drain(20);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 399) != 0);
            bus.valid_in = ($urandom_range(0, 5) == 0);
            bus.ready    = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NR; i++) bus.in[i] = $urandom;
            tick();
        end
        rst          = 1'b1;
        bus.valid_in = 1'b0;
        bus.ready    = 1'b1;
        drain(60);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
